slow_to_fast: RTL



---
 rtl/slow_to_fast.sv | 106 ++++++++++
 1 files changed

// File: rtl/slow_to_fast.sv
// slow_to_fast: FAST_clk-domain capture of a slow bus, with S2F_CHANGE_ONLY_EN suppressing repeat words
module slow_to_fast #(
  parameter int WIDTH         = 12,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             FAST_clk,
  input  logic             reset,
  input  logic             SLOW_clk,
  input  logic [WIDTH-1:0] slow_data,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overflow,
  output logic             missed_edge,
  input  logic             flag_clr
);
  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  typedef enum logic [1:0] {ARM, WAIT_EDGE, SETTLE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, fill_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic s, s_prev_q, rise, capture, post, accept;
  logic valid_q, valid_d, ovf_q, ovf_d, missed_q, missed_d;
  assign s      = sync_q[SYNC_STAGES-1];
  assign rise   = s & ~s_prev_q;
  assign accept = valid_q & data_ready;
  // SLOW_clk synchronizer; fill_q marks when the chain holds real samples so ARM never trusts reset zeros
  always_ff @(posedge FAST_clk) begin
    if (reset) begin
      sync_q   <= '0;
      fill_q   <= '0;
      s_prev_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], SLOW_clk};
      fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      s_prev_q <= s;
    end
  end
  // FSM state and settle counter
  always_ff @(posedge FAST_clk) begin
    if (reset) begin
      state_q <= ARM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state: arm on a genuinely low SLOW_clk, settle after each rise, then capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      ARM:       if (fill_q[SYNC_STAGES-1] && !s) state_d = WAIT_EDGE;
      WAIT_EDGE: if (rise) begin
        state_d = SETTLE;
        cnt_d   = CW'(SETTLE_CYCLES);
      end
      SETTLE: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else begin
        capture = 1'b1;
        state_d = WAIT_EDGE;
      end
      default: state_d = ARM;
    endcase
  end
`ifdef S2F_CHANGE_ONLY_EN
  logic seen_q;
  assign post = capture & (~seen_q | (slow_data != data_q));
  // remembers that a word has been posted since reset so the first capture always posts
  always_ff @(posedge FAST_clk) begin
    if (reset) seen_q <= 1'b0;
    else if (post) seen_q <= 1'b1;
  end
`else
  assign post = capture;
`endif
  // holding register, handshake and sticky flags; a set event beats flag_clr
  always_comb begin
    data_d   = post ? slow_data : data_q;
    valid_d  = post | (valid_q & ~accept);
    ovf_d    = (post & valid_q & ~data_ready) | (ovf_q & ~flag_clr);
    missed_d = ((state_q == SETTLE) & rise) | (missed_q & ~flag_clr);
  end
  // output registers
  always_ff @(posedge FAST_clk) begin
    if (reset) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      missed_q <= missed_d;
    end
  end
  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign overflow    = ovf_q;
  assign missed_edge = missed_q;
endmodule
